rr_arbiter: RTL

//  Round-robin arbiter sharing one resource (bus/port) among N requesters.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/rr_arbiter_prio_enc_valid.sv | 23 ++
 rtl/rr_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Holds the arbiter state encoding, default sizing constants and the modulo-N rotation helper.
package arb_pkg;

    localparam int ARB_N        = 8;
    localparam int ARB_MAX_HOLD = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // (base + off) mod n for base, off < n, wrapped by compare so non-power-of-2 n works.
    function automatic int unsigned rot_idx(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
        int unsigned s;
        s = base + off;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/rr_arbiter_prio_enc_valid.sv
// Fixed-priority encoder: lowest set bit wins, valid flags a non-zero input.
module prio_enc_valid #(
    parameter int N   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_vec,
    output logic [IDW-1:0] idx,
    output logic           valid
);

    // Scanning downward lets the lowest index overwrite any higher hit.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                idx   = IDW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotates requests by a pointer, fixed-priority encodes, holds grant until release.
// Optional forced release after MAX_HOLD cycles when built with RR_ARB_TIMEOUT_EN.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int IDW      = $clog2(N),
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout,
    output arb_state_t     state_dbg,
    output logic [IDW-1:0] ptr_dbg
);

    arb_state_t     state_q;
    logic [IDW-1:0] ptr_q;
    logic [N-1:0]   gnt_q;
    logic [IDW-1:0] gnt_id_q;
    logic           timeout_q;

    logic           force_w;
    logic           release_w;
    logic           grant_load;
    logic [IDW-1:0] next_ptr;
    logic [IDW-1:0] arb_ptr;
    logic [N-1:0]   req_m;
    logic [N-1:0]   rot_req;
    logic [IDW-1:0] enc_idx;
    logic           enc_valid;
    logic [IDW-1:0] win_id;

    assign release_w  = (state_q == BUSY) && (!req[gnt_id_q] || force_w);
    assign next_ptr   = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + 1'b1;
    // On release the new pointer is used in the same cycle so the next winner follows directly.
    assign arb_ptr    = release_w ? next_ptr : ptr_q;
    assign grant_load = ((state_q == IDLE) || release_w) && enc_valid;

    // The outgoing holder is excluded so a forced release always drops its grant.
    always_comb begin
        req_m = req;
        if (state_q == BUSY) begin
            req_m[gnt_id_q] = 1'b0;
        end
    end

    always_comb begin
        rot_req = '0;
        for (int j = 0; j < N; j++) begin
            rot_req[j] = req_m[IDW'(rot_idx(32'(arb_ptr), j, N))];
        end
    end

    prio_enc_valid #(
        .N   (N),
        .IDW (IDW)
    ) u_enc (
        .req_vec (rot_req),
        .idx     (enc_idx),
        .valid   (enc_valid)
    );

    assign win_id = IDW'(rot_idx(32'(arb_ptr), 32'(enc_idx), N));

`ifdef RR_ARB_TIMEOUT_EN
    localparam int HCW = $clog2(MAX_HOLD + 1);
    logic [HCW-1:0] hold_q;

    assign force_w = (state_q == BUSY) && req[gnt_id_q] && (hold_q == HCW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (grant_load) begin
            hold_q <= '0;
        end else if (state_q == BUSY) begin
            hold_q <= hold_q + 1'b1;
        end
    end
`else
    logic unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;
    assign force_w         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_w;
            if ((state_q == IDLE) || release_w) begin
                if (release_w) begin
                    ptr_q <= next_ptr;
                end
                if (grant_load) begin
                    state_q  <= BUSY;
                    gnt_q    <= N'(1) << win_id;
                    gnt_id_q <= win_id;
                end else begin
                    state_q  <= IDLE;
                    gnt_q    <= '0;
                    gnt_id_q <= '0;
                end
            end
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;
    assign state_dbg = state_q;
    assign ptr_dbg   = ptr_q;

endmodule
